// File: rtl/mem_request_queue_if.sv
// Signal bundle between EX/MEM, the MEM-stage request queue and the data aligner.
// slave = queue view; master = upstream stage plus aligner side.
interface mem_request_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int SCL_W  = 16,
  parameter int VEC_W  = 256
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              req_valid;
  logic              req_ready;
  logic              req_memtoReg;
  logic              req_memWrite;
  logic              req_memSrc;
  logic [ADDR_W-1:0] req_address;
  logic [SCL_W-1:0]  req_scalarData;
  logic [VEC_W-1:0]  req_vectorData;
  logic              flush;

  logic              memtoRegM;
  logic              memWriteM;
  logic              memSrcM;
  logic [ADDR_W-1:0] address;
  logic [SCL_W-1:0]  scalarDataIn;
  logic [VEC_W-1:0]  vectorDataIn;
  logic              busy;
  logic              ld_done;
  logic              st_done;

  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;

  modport master (
    output req_valid, req_memtoReg, req_memWrite, req_memSrc, req_address,
           req_scalarData, req_vectorData, flush, busy,
    input  req_ready, memtoRegM, memWriteM, memSrcM, address, scalarDataIn,
           vectorDataIn, ld_done, st_done, count, empty, full
  );

  modport slave (
    input  req_valid, req_memtoReg, req_memWrite, req_memSrc, req_address,
           req_scalarData, req_vectorData, flush, busy,
    output req_ready, memtoRegM, memWriteM, memSrcM, address, scalarDataIn,
           vectorDataIn, ld_done, st_done, count, empty, full
  );
endinterface

// File: rtl/mem_request_queue.sv
// MEM-stage request FIFO feeding the data aligner one load/store at a time.
// Optional MRQ_BYPASS_EN: empty-queue requests reach the aligner in the same cycle.
//
// state | meaning
// IDLE  | queue empty, nothing presented to the aligner
// ISSUE | head entry presented, waiting for busy=0
// DRAIN | flushed while busy; only the head remains, pushes blocked
module mem_request_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int SCL_W  = 16,
  parameter int VEC_W  = 256
) (
  input logic                clk,
  input logic                reset,
  mem_request_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  typedef struct packed {
    logic              is_st;
    logic              src;
    logic [ADDR_W-1:0] addr;
    logic [SCL_W-1:0]  sdata;
    logic [VEC_W-1:0]  vdata;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           req_ent;
  entry_t           head;
  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             req_ready;
  logic             accept;
  logic             byp;
  logic             present;
  logic             complete;
  logic             pop;
  logic             push;
  logic             wr_en;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign req_ready = reset & ~full & (state_q != DRAIN);
  // Requests that are neither load nor store are acknowledged but never stored.
  assign accept    = bus.req_valid & req_ready & (bus.req_memtoReg | bus.req_memWrite);

  assign req_ent.is_st = bus.req_memWrite;
  assign req_ent.src   = bus.req_memSrc;
  assign req_ent.addr  = bus.req_address;
  assign req_ent.sdata = bus.req_scalarData;
  assign req_ent.vdata = bus.req_vectorData;

`ifdef MRQ_BYPASS_EN
  assign byp = (state_q == IDLE) & accept & ~bus.flush;
`else
  assign byp = 1'b0;
`endif

  assign head     = byp ? req_ent : mem_q[rd_ptr_q];
  assign present  = (state_q != IDLE) | byp;
  assign complete = present & ~bus.busy;
  assign pop      = complete & ~byp;
  // A bypassed request that completes at once is never written to storage.
  assign push     = accept & ~bus.flush & ~(byp & complete);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_en    = 1'b0;
    if (bus.flush && (state_q == IDLE || complete)) begin
      state_d  = IDLE;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else if (bus.flush) begin
      // Head is in flight: keep it, drop everything behind it.
      state_d  = DRAIN;
      count_d  = CNT_W'(1);
      wr_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      if (push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      case (state_q)
        IDLE, ISSUE: state_d = (count_d != '0) ? ISSUE : IDLE;
        DRAIN:       state_d = complete ? IDLE : DRAIN;
        default:     state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= req_ent;
  end

  assign bus.req_ready    = req_ready;
  assign bus.memtoRegM    = present & ~head.is_st;
  assign bus.memWriteM    = present & head.is_st;
  assign bus.memSrcM      = present & head.src;
  assign bus.address      = present ? head.addr  : '0;
  assign bus.scalarDataIn = present ? head.sdata : '0;
  assign bus.vectorDataIn = present ? head.vdata : '0;
  assign bus.ld_done      = complete & ~head.is_st;
  assign bus.st_done      = complete & head.is_st;
  assign bus.count        = count_q;
  assign bus.empty        = (count_q == '0);
  assign bus.full         = full;
endmodule
